aqp_esp_uart_rx: RTL and testbench
==================================

// Module: aqp_esp_uart_rx
//
// PURPOSE
//   9-bit UART receiver for the ESP32 link. It deserialises the ESP TX line
//   into 9-bit words (bit 8 = control/command flag, bits 7:0 = payload) and
//   writes them into the downstream ESP UART RX FIFO. It drives RTS flow
//   control from the FIFO's almost-full flag, and flags framing and overflow
//   errors.
//
// PARAMETERS
//   CLKS_PER_BIT  16  clk cycles per UART bit; must be >= 4 (16 -> ~1.79 Mbaud at 28.636 MHz)
//
// PORTS
//   clk               in   1  system clock; single clock domain
//   reset             in   1  synchronous, active-high reset
//   uart_rxd          in   1  serial data from ESP; asynchronous; idles high
//   uart_rts_n        out  1  active-low request-to-send towards the ESP
//   fifo_full         in   1  FIFO full flag
//   fifo_almost_full  in   1  FIFO almost-full flag (>= 8 entries)
//   wrdata            out  9  received word; bit 8 = 9th data bit
//   wr_en             out  1  one-cycle write strobe to the FIFO
//   framing_err       out  1  one-cycle pulse: stop bit sampled low
//   overflow_err      out  1  one-cycle pulse: word dropped because FIFO full
//
// BEHAVIOUR
//   - Reset values: wrdata=0, wr_en=0, framing_err=0, overflow_err=0,
//     uart_rts_n=1, synchroniser stages=1, state=IDLE, counters=0.
//   - uart_rxd passes through a 2-FF synchroniser (reset to 1); rxd_s is the
//     synchronised value. All sampling uses rxd_s.
//   - Bit counter width is $clog2(CLKS_PER_BIT); the counter reloads on every
//     state entry.
//   - State machine:
//       IDLE   : rxd_s==0 -> START, with bit counter loaded for CLKS_PER_BIT/2.
//       START  : at mid-bit, rxd_s==1 -> IDLE (glitch, no output);
//                rxd_s==0 -> DATA, bit index=0.
//       DATA   : sample every CLKS_PER_BIT cycles; shift in LSB first;
//                9 bits (index 0..8), then -> STOP.
//       STOP   : at mid-bit, rxd_s==1 -> emit word, -> IDLE;
//                rxd_s==0 -> framing_err pulse, no write, -> BREAK.
//       BREAK  : wait for rxd_s==1 -> IDLE. Covers line break and held-low
//                line; no further errors are raised while here.
//   - Emit: the cycle after the stop-bit sample, wrdata<=shift register.
//       fifo_full==0 : wr_en=1 for exactly 1 cycle.
//       fifo_full==1 : wr_en=0 and overflow_err=1 for 1 cycle; word dropped.
//     wrdata holds its value until the next emit.
//   - Latency: stop-bit mid-sample -> wr_en = 1 clk. rxd pin -> rxd_s = 2 clk.
//   - A start bit may be detected in the same cycle that a word is emitted,
//     so back-to-back frames with one stop bit are received without loss.
//   - uart_rts_n is a register: uart_rts_n <= fifo_almost_full.
//     It deasserts (goes 1) 1 clk after almost_full rises. This leaves 8 FIFO
//     slots of headroom for words already in flight at the ESP.
//   - Reset asserted mid-frame: abort to IDLE in the next cycle; no wr_en and
//     no error pulses. A frame still on the line after reset may be
//     mis-framed; it is resynchronised via BREAK/IDLE.
//   - wr_en, framing_err and overflow_err are mutually exclusive in any cycle.
//
// STRUCTURE
//   - Shared header aqp_esp_uart_defs.vh holds: ESP_UART_WORD_W=9, the
//     default CLKS_PER_BIT, and the state encodings IDLE/START/DATA/STOP/BREAK.
//     The matching TX block uses the same header.
//   - Sub-module aqp_sync2: generic 2-FF synchroniser with parameterised
//     reset value (1 here).
//   - Single always block per register group; no combinational outputs.
//
// TESTING (CLKS_PER_BIT=16, ideal bit timing unless stated)
//   1. Frame 0x1A5 (bit8=1), good stop -> one wr_en, wrdata=9'h1A5,
//      no error pulses; wr_en 1 clk after the stop mid-sample.
//   2. Two back-to-back frames 0x055 then 0x100, 1 stop bit each ->
//      two wr_en pulses, wrdata 9'h055 then 9'h100.
//   3. 4-clk low glitch on idle line -> returns to IDLE; no wr_en and no
//      errors.
//   4. Frame 0x0FF with stop bit low, line then held low for 40 bits ->
//      one framing_err pulse, no wr_en; next valid frame 0x003 after line
//      high -> wrdata=9'h003.
//   5. fifo_full=1 during frame 0x123 -> overflow_err pulse, wr_en=0.
//      Toggle fifo_almost_full 0->1 -> uart_rts_n 0->1 one clk later.
//   6. reset pulse at data bit 4 of frame 0x1FF -> no wr_en; all outputs at
//      reset values, uart_rts_n=1 during reset. Next frame 0x0AA is received
//      correctly.

Source files
------------

// File: rtl/aqp_esp_uart_rx_pkg.sv
// Shared definitions for the ESP32 9-bit UART link: word width, default bit
// timing and receiver state encoding. The TX block imports the same package.
package aqp_esp_uart_rx_pkg;

  localparam int ESP_UART_WORD_W       = 9;
  localparam int ESP_UART_CLKS_PER_BIT = 16;
  localparam int ESP_UART_LAST_BIT     = ESP_UART_WORD_W - 1;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_STOP  = 3'd3,
    ST_BREAK = 3'd4
  } rx_state_e;

  // Result of a stop-bit decision, registered into the output pulses.
  typedef struct packed {
    logic stop_ok;
    logic ferr;
  } rx_evt_t;

endpackage

// File: rtl/aqp_sync2.sv
// Generic two-flop synchroniser for a single asynchronous bit; the reset value
// should match the idle level of the incoming line.
module aqp_sync2 #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk) begin
    if (reset) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/aqp_esp_uart_rx.sv
// 9-bit UART receiver for the ESP32 link: deserialises uart_rxd into FIFO
// writes, drives RTS from FIFO almost-full and pulses framing/overflow errors.
module aqp_esp_uart_rx
  import aqp_esp_uart_rx_pkg::*;
#(
  parameter int CLKS_PER_BIT = ESP_UART_CLKS_PER_BIT
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       uart_rxd,
  output logic                       uart_rts_n,
  input  logic                       fifo_full,
  input  logic                       fifo_almost_full,
  output logic [ESP_UART_WORD_W-1:0] wrdata,
  output logic                       wr_en,
  output logic                       framing_err,
  output logic                       overflow_err
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] FULL_LD = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LD = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [3:0]    LAST_IDX = 4'(ESP_UART_LAST_BIT);

  logic rxd_s;

  aqp_sync2 #(.RST_VAL(1'b1)) u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (uart_rxd),
    .q     (rxd_s)
  );

  rx_state_e                  state, state_nxt;
  logic [CW-1:0]              cnt, cnt_nxt;
  logic [3:0]                 bit_idx, bit_idx_nxt;
  logic [ESP_UART_WORD_W-1:0] shreg, shreg_nxt;
  rx_evt_t                    evt;
  logic                       tick;

  assign tick = (cnt == '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      shreg   <= '0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      bit_idx <= bit_idx_nxt;
      shreg   <= shreg_nxt;
    end
  end

  // The counter free-runs down to zero and parks there; every transition
  // reloads it, so each state measures time from its own entry.
  always_comb begin
    state_nxt   = state;
    cnt_nxt     = tick ? cnt : cnt - 1'b1;
    bit_idx_nxt = bit_idx;
    shreg_nxt   = shreg;
    evt         = '0;
    case (state)
      ST_IDLE: begin
        if (!rxd_s) begin
          state_nxt = ST_START;
          cnt_nxt   = HALF_LD;
        end
      end
      ST_START: begin
        if (tick) begin
          if (rxd_s) begin
            state_nxt = ST_IDLE;
            cnt_nxt   = '0;
          end else begin
            state_nxt   = ST_DATA;
            cnt_nxt     = FULL_LD;
            bit_idx_nxt = '0;
          end
        end
      end
      ST_DATA: begin
        if (tick) begin
          shreg_nxt = {rxd_s, shreg[ESP_UART_WORD_W-1:1]};
          cnt_nxt   = FULL_LD;
          if (bit_idx == LAST_IDX) begin
            state_nxt = ST_STOP;
          end else begin
            bit_idx_nxt = bit_idx + 4'd1;
          end
        end
      end
      ST_STOP: begin
        if (tick) begin
          cnt_nxt = '0;
          if (rxd_s) begin
            state_nxt   = ST_IDLE;
            evt.stop_ok = 1'b1;
          end else begin
            state_nxt = ST_BREAK;
            evt.ferr  = 1'b1;
          end
        end
      end
      ST_BREAK: begin
        // Held-low line: sit here silently until it returns to idle.
        if (rxd_s) begin
          state_nxt = ST_IDLE;
          cnt_nxt   = '0;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wrdata       <= '0;
      wr_en        <= 1'b0;
      framing_err  <= 1'b0;
      overflow_err <= 1'b0;
    end else begin
      wr_en        <= evt.stop_ok & ~fifo_full;
      overflow_err <= evt.stop_ok & fifo_full;
      framing_err  <= evt.ferr;
      if (evt.stop_ok) wrdata <= shreg;
    end
  end

  // Registered so RTS tracks almost-full with exactly one clock of delay.
  always_ff @(posedge clk) begin
    if (reset) uart_rts_n <= 1'b1;
    else       uart_rts_n <= fifo_almost_full;
  end

endmodule

// File: tb/tb_aqp_esp_uart_rx.sv
// Directed bench for aqp_esp_uart_rx at 16 clocks per bit.
module tb_aqp_esp_uart_rx;

  localparam int CPB = 16;
  // pin edge -> 2 sync -> 1 detect -> half bit -> 10 bit periods to stop mid
  localparam int STOP_LAT = 171;

  logic       clk = 1'b0;
  logic       reset;
  logic       uart_rxd;
  logic       uart_rts_n;
  logic       fifo_full;
  logic       fifo_almost_full;
  logic [8:0] wrdata;
  logic       wr_en;
  logic       framing_err;
  logic       overflow_err;

  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int wr_cnt   = 0;
  int ferr_cnt = 0;
  int ovf_cnt  = 0;
  int excl_cnt = 0;
  int last_wr_cyc = 0;
  int t0 = 0;
  logic [8:0] wr_log[$];

  aqp_esp_uart_rx #(.CLKS_PER_BIT(CPB)) dut (
    .clk              (clk),
    .reset            (reset),
    .uart_rxd         (uart_rxd),
    .uart_rts_n       (uart_rts_n),
    .fifo_full        (fifo_full),
    .fifo_almost_full (fifo_almost_full),
    .wrdata           (wrdata),
    .wr_en            (wr_en),
    .framing_err      (framing_err),
    .overflow_err     (overflow_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (wr_en === 1'b1) begin
      wr_cnt++;
      last_wr_cyc = cyc;
      wr_log.push_back(wrdata);
    end
    if (framing_err === 1'b1) ferr_cnt++;
    if (overflow_err === 1'b1) ovf_cnt++;
    if ((int'(wr_en) + int'(framing_err) + int'(overflow_err)) > 1) excl_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Called on a negedge; returns on a negedge with the stop level still driven.
  task automatic send_frame(input logic [8:0] w, input logic stop);
    logic [10:0] bits;
    bits = {stop, w, 1'b0};
    t0 = cyc;
    for (int i = 0; i < 11; i++) begin
      uart_rxd = bits[i];
      repeat (CPB) @(negedge clk);
    end
  endtask

  task automatic idle_bits(input int n);
    uart_rxd = 1'b1;
    repeat (n * CPB) @(negedge clk);
  endtask

  initial begin
    int wr0;
    reset = 1'b1;
    uart_rxd = 1'b1;
    fifo_full = 1'b0;
    fifo_almost_full = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_wrdata", 32'(wrdata), 32'h0);
    check("rst_wr_en", 32'(wr_en), 32'h0);
    check("rst_ferr", 32'(framing_err), 32'h0);
    check("rst_ovf", 32'(overflow_err), 32'h0);
    check("rst_rts_n", 32'(uart_rts_n), 32'h1);
    reset = 1'b0;
    @(negedge clk);
    check("rts_after_rst", 32'(uart_rts_n), 32'h0);
    idle_bits(1);

    // 1: single frame with bit 8 set
    send_frame(9'h1A5, 1'b1);
    idle_bits(2);
    check("t1_wr_cnt", 32'(wr_cnt), 32'd1);
    check("t1_wrdata", 32'(wrdata), 32'h1A5);
    check("t1_latency", 32'(last_wr_cyc - t0), 32'(STOP_LAT));
    check("t1_ferr", 32'(ferr_cnt), 32'd0);
    check("t1_ovf", 32'(ovf_cnt), 32'd0);

    // 2: back-to-back frames, one stop bit each
    send_frame(9'h055, 1'b1);
    send_frame(9'h100, 1'b1);
    idle_bits(2);
    check("t2_wr_cnt", 32'(wr_cnt), 32'd3);
    check("t2_word0", 32'(wr_log[1]), 32'h055);
    check("t2_word1", 32'(wr_log[2]), 32'h100);

    // 3: short low glitch on idle line
    uart_rxd = 1'b0;
    repeat (4) @(negedge clk);
    idle_bits(3);
    check("t3_wr_cnt", 32'(wr_cnt), 32'd3);
    check("t3_ferr", 32'(ferr_cnt), 32'd0);
    check("t3_ovf", 32'(ovf_cnt), 32'd0);

    // 4: bad stop bit then 40-bit break, then a clean frame
    send_frame(9'h0FF, 1'b0);
    repeat (40 * CPB) @(negedge clk);
    idle_bits(2);
    check("t4_ferr", 32'(ferr_cnt), 32'd1);
    check("t4_no_wr", 32'(wr_cnt), 32'd3);
    send_frame(9'h003, 1'b1);
    idle_bits(2);
    check("t4_wr_cnt", 32'(wr_cnt), 32'd4);
    check("t4_wrdata", 32'(wrdata), 32'h003);

    // 5: FIFO full drops the word; RTS follows almost-full one clock later
    fifo_full = 1'b1;
    send_frame(9'h123, 1'b1);
    idle_bits(2);
    fifo_full = 1'b0;
    check("t5_ovf", 32'(ovf_cnt), 32'd1);
    check("t5_no_wr", 32'(wr_cnt), 32'd4);
    check("t5_wrdata", 32'(wrdata), 32'h123);
    fifo_almost_full = 1'b1;
    check("t5_rts_before", 32'(uart_rts_n), 32'h0);
    @(negedge clk);
    check("t5_rts_after", 32'(uart_rts_n), 32'h1);
    fifo_almost_full = 1'b0;
    @(negedge clk);
    check("t5_rts_release", 32'(uart_rts_n), 32'h0);

    // 6: reset during data bit 4, then a clean frame
    wr0 = wr_cnt;
    fork
      send_frame(9'h1FF, 1'b1);
      begin
        repeat (5 * CPB + CPB / 2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("t6_rst_wrdata", 32'(wrdata), 32'h0);
        check("t6_rst_wr_en", 32'(wr_en), 32'h0);
        check("t6_rst_ferr", 32'(framing_err), 32'h0);
        check("t6_rst_ovf", 32'(overflow_err), 32'h0);
        check("t6_rst_rts", 32'(uart_rts_n), 32'h1);
        reset = 1'b0;
      end
    join
    idle_bits(3);
    check("t6_no_wr", 32'(wr_cnt), 32'(wr0));
    send_frame(9'h0AA, 1'b1);
    idle_bits(2);
    check("t6_wr_cnt", 32'(wr_cnt), 32'(wr0 + 1));
    check("t6_wrdata", 32'(wrdata), 32'h0AA);
    check("t6_ferr_total", 32'(ferr_cnt), 32'd1);
    check("t6_ovf_total", 32'(ovf_cnt), 32'd1);

    check("excl_pulses", 32'(excl_cnt), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
